// File: rtl/wb_master_bfm.sv
// wb_master_bfm: Wishbone B4 classic-cycle initiator running single/incrementing-burst commands
// Ports: wb_clk_i/wb_resetn clock and async active-low reset; cmd_* valid/ready command port
// (we, start addr, byte selects, beats-1); wr_data/wr_next write-data pull; rd_data/rd_valid
// read stream; done/err completion strobes; wb_* Wishbone classic master bus.
module wb_master_bfm #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int SW      = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [SW-1:0] cmd_sel,
  input  logic [7:0]    cmd_len,
  input  logic [DW-1:0] wr_data,
  output logic          wr_next,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          done,
  output logic          err,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [SW-1:0] wb_sel_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic          wb_ack_i,
  input  logic [DW-1:0] wb_dat_i
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BEAT = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [DW-1:0] dat_q, dat_d, rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d, done_q, done_d, err_q, err_d;

  assign cmd_ready = state_q == IDLE;
  // write data is pulled in the accept cycle and in every inter-beat gap
  assign wr_next   = (state_q == IDLE && cmd_valid && cmd_we) || (state_q == GAP && we_q);
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_sel_o  = sel_q;
  assign wb_dat_o  = dat_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    dat_d      = dat_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = BEAT;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = cmd_we;
        sel_d   = cmd_sel;
        addr_d  = cmd_addr;
        cnt_d   = cmd_len;
        to_d    = '0;
        dat_d   = cmd_we ? wr_data : dat_q;
      end
      BEAT: if (wb_ack_i) begin
        // an ack coinciding with timeout expiry still completes the beat
        rd_data_d  = we_q ? rd_data_q : wb_dat_i;
        rd_valid_d = !we_q;
        stb_d      = 1'b0;
        if (cnt_q != 8'd0) begin
          cnt_d   = cnt_q - 8'd1;
          addr_d  = addr_q + AW'(1);
          state_d = GAP;
        end else begin
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end else if (to_q == TO_LAST) begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        to_d = to_q + TW'(1);
      end
      GAP: begin
        state_d = BEAT;
        stb_d   = 1'b1;
        to_d    = '0;
        dat_d   = we_q ? wr_data : dat_q;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      to_q       <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      dat_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      dat_q      <= dat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_wb_master_bfm.sv
// tb_wb_master_bfm: directed and randomized checks of wb_master_bfm against a beat-level model
module tb_wb_master_bfm;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic [7:0]    cmd_len = '0;
  logic [DW-1:0] wr_data;
  logic          cmd_ready, wr_next, rd_valid, done, err;
  logic [DW-1:0] rd_data;
  logic          cyc, stb, we;
  logic [AW-1:0] addr;
  logic [SW-1:0] sel;
  logic [DW-1:0] dat_o;
  logic          ack = 1'b0;
  logic [DW-1:0] dat_i = '0;

  wb_master_bfm #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_resetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_sel(cmd_sel), .cmd_len(cmd_len), .wr_data(wr_data), .wr_next(wr_next),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_addr_o(addr), .wb_sel_o(sel),
    .wb_dat_o(dat_o), .wb_ack_i(ack), .wb_dat_i(dat_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // write-data source: wr_idx advances on every wr_next, so beat i of a command uses wbase+i
  logic [DW-1:0] wr_words [0:511];
  logic [8:0]    wr_idx = '0;
  logic [8:0]    wbase = '0;
  assign wr_data = wr_words[wr_idx];
  always @(posedge clk) if (wr_next) wr_idx <= wr_idx + 9'd1;

  // slave: beat k of the current command waits wait_tab[k] cycles, then acks with rd_tab[k]
  logic [DW-1:0] rd_tab [0:511];
  int            wait_tab [0:511];
  int            bidx = 0;
  int            bbase = 0;
  int            wcnt = 0;
  bit            noise = 1'b0;
  always @(posedge clk) begin
    #1;
    if (cyc && stb) begin
      ack = (wcnt == wait_tab[(bidx - bbase) & 511]);
      dat_i = ack ? rd_tab[(bidx - bbase) & 511] : $urandom;
      wcnt++;
    end else begin
      wcnt = 0;
      ack = noise && ($urandom_range(1) == 1);
      dat_i = $urandom;
    end
  end

  // monitor: everything sampled mid-cycle
  int          cyc_n = 0;
  logic [62:0] beats [$];
  logic [31:0] rds [$];
  int          done_q [$];
  int          err_q [$];
  int          rises [$];
  int          wr_cnt = 0, stb_cnt = 0, gap_cnt = 0, viol_cnt = 0;
  int          acc_cyc = 0, end_cyc = 0;
  bit          end_ready = 1'b0;
  bit          stb_prev = 1'b0;
  logic [30:0] held = '0;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(negedge clk) begin
    if (cyc && stb && ack) begin
      beats.push_back({we, addr, sel, (we ? dat_o : 32'h0)});
      bidx++;
    end
    if (stb) stb_cnt++;
    if (cyc && !stb) gap_cnt++;
    if (stb && !stb_prev) rises.push_back(cyc_n);
    if (stb && stb_prev && {we, addr, sel} != held) viol_cnt++;
    held = {we, addr, sel};
    stb_prev = stb;
    if (rd_valid) rds.push_back(rd_data);
    if (wr_next) wr_cnt++;
    if (done) done_q.push_back(cyc_n);
    if (err) err_q.push_back(cyc_n);
    if (done || err) begin
      end_cyc = cyc_n;
      end_ready = cmd_ready;
    end
    if (cmd_valid && cmd_ready) acc_cyc = cyc_n;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int len, input int w);
    wbase = wr_idx;
    for (int i = 0; i <= len; i++) begin
      wait_tab[i] = w;
      rd_tab[i] = $urandom;
      wr_words[wbase + 9'(i)] = $urandom;
    end
  endtask

  // Issues one command and checks it against the beat-level expectation built from wait_tab:
  // the first beat whose wait reaches TO is aborted; every other beat costs wait+1 stb cycles
  // plus one gap cycle between beats.
  task automatic run_cmd(input string tag, input bit w, input logic [AW-1:0] a,
                         input logic [SW-1:0] s, input int len);
    int n_ok, sum, stb_exp, gap_exp, wr_exp, lim, k, nb, nr;
    int b0, r0, d0, e0, w0, s0, g0, v0;
    bit abort;
    n_ok = 0;
    sum = 0;
    abort = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (wait_tab[i] >= TO) begin
        abort = 1'b1;
        break;
      end
      n_ok++;
      sum += wait_tab[i] + 1;
    end
    stb_exp = sum + (abort ? TO : 0);
    gap_exp = abort ? n_ok : len;
    wr_exp = w ? (abort ? n_ok + 1 : len + 1) : 0;
    @(posedge clk);
    #1;
    b0 = beats.size(); r0 = rds.size(); d0 = done_q.size(); e0 = err_q.size();
    w0 = wr_cnt; s0 = stb_cnt; g0 = gap_cnt; v0 = viol_cnt;
    bbase = bidx;
    cmd_valid = 1'b1; cmd_we = w; cmd_addr = a; cmd_sel = s; cmd_len = 8'(len);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lim = stb_exp + gap_exp + 10;
    k = 0;
    while (done_q.size() == d0 && err_q.size() == e0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    #1;
    check({tag, "_finished"}, 64'(k < lim), 64'd1);
    check({tag, "_done"}, 64'(done_q.size() - d0), abort ? 64'd0 : 64'd1);
    check({tag, "_err"}, 64'(err_q.size() - e0), abort ? 64'd1 : 64'd0);
    check({tag, "_latency"}, 64'(end_cyc - acc_cyc), 64'(1 + stb_exp + gap_exp));
    check({tag, "_ready_at_end"}, 64'(end_ready), 64'd1);
    check({tag, "_stb_cycles"}, 64'(stb_cnt - s0), 64'(stb_exp));
    check({tag, "_gap_cycles"}, 64'(gap_cnt - g0), 64'(gap_exp));
    check({tag, "_wr_next"}, 64'(wr_cnt - w0), 64'(wr_exp));
    check({tag, "_stable"}, 64'(viol_cnt - v0), 64'd0);
    nb = beats.size() - b0;
    check({tag, "_beats"}, 64'(nb), 64'(n_ok));
    for (int i = 0; i < nb && i < n_ok; i++)
      check($sformatf("%s_beat%0d", tag, i), 64'(beats[b0 + i]),
            64'({w, AW'(a + AW'(i)), s, (w ? wr_words[wbase + 9'(i)] : 32'h0)}));
    nr = rds.size() - r0;
    check({tag, "_rd_count"}, 64'(nr), w ? 64'd0 : 64'(n_ok));
    for (int i = 0; i < nr && i < n_ok; i++)
      check($sformatf("%s_rd%0d", tag, i), 64'(rds[r0 + i]), 64'(rd_tab[i]));
  endtask

  initial begin
    int k, b0, d0, e0, r0, q0, len, r_a, r_b;
    bit w;
    logic [AW-1:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_bus", 64'({cyc, stb, we, addr, sel}), 64'd0);
    check("rst_wdat", 64'(dat_o), 64'd0);
    check("rst_rd", 64'({rd_data, rd_valid}), 64'd0);
    check("rst_strobes", 64'({wr_next, done, err}), 64'd0);
    rst_n = 1'b1;

    fill(0, 3);
    wr_words[wbase] = 32'hDEADBEEF;
    run_cmd("single_wr", 1'b1, 26'h0000010, 4'hF, 0);

    fill(3, 0);
    rd_tab[0] = 32'h11; rd_tab[1] = 32'h22; rd_tab[2] = 32'h33; rd_tab[3] = 32'h44;
    run_cmd("rd_burst", 1'b0, 26'h0000100, 4'hF, 3);

    fill(1, 1);
    run_cmd("wrap_wr", 1'b1, 26'h3FFFFFF, 4'h5, 1);

    fill(0, 1000);
    run_cmd("timeout_rd", 1'b0, 26'h0000200, 4'hF, 0);

    fill(0, TO - 1);
    run_cmd("ack_at_expiry", 1'b0, 26'h0000300, 4'hC, 0);

    fill(0, TO);
    run_cmd("ack_after_expiry", 1'b1, 26'h0000300, 4'h3, 0);

    fill(3, 1);
    wait_tab[2] = 1000;
    run_cmd("timeout_mid_burst", 1'b1, 26'h0000400, 4'hF, 3);

    fill(255, 0);
    run_cmd("max_burst", 1'b0, 26'h3FFFF80, 4'hF, 255);

    // reset during beat 2 of an 8-beat write
    fill(7, 2);
    @(posedge clk);
    #1;
    bbase = bidx; b0 = beats.size(); d0 = done_q.size(); e0 = err_q.size();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 26'h0002000; cmd_sel = 4'hF; cmd_len = 8'd7;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    k = 0;
    while (beats.size() == b0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    #3;
    check("rst_mid_stb_before", 64'({cyc, stb}), 64'b11);
    rst_n = 1'b0;
    #1;
    check("rst_mid_bus_released", 64'({cyc, stb}), 64'd0);
    check("rst_mid_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check("rst_mid_no_done_err", 64'({done_q.size() - d0, err_q.size() - e0}), 64'd0);
    fill(1, 0);
    run_cmd("after_rst", 1'b1, 26'h0000055, 4'h9, 1);

    // two single reads back to back with cmd_valid held; acks toggle randomly outside BEAT
    wait_tab[0] = 0; wait_tab[1] = 0;
    rd_tab[0] = $urandom; rd_tab[1] = $urandom;
    noise = 1'b1;
    @(posedge clk);
    #1;
    bbase = bidx; b0 = beats.size(); d0 = done_q.size(); r0 = rds.size(); q0 = rises.size();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h0000A00; cmd_sel = 4'hF; cmd_len = 8'd0;
    @(posedge clk);
    #1;
    cmd_addr = 26'h0000B00;
    k = 0;
    while (done_q.size() == d0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    cmd_valid = 1'b0;
    k = 0;
    while (done_q.size() < d0 + 2 && k < 20) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    #1;
    noise = 1'b0;
    check("b2b_done_count", 64'(done_q.size() - d0), 64'd2);
    check("b2b_rise_count", 64'(rises.size() - q0), 64'd2);
    r_a = (rises.size() >= q0 + 2) ? rises[q0] : -100;
    r_b = (rises.size() >= q0 + 2) ? rises[q0 + 1] : -100;
    check("b2b_spacing", 64'(r_b - r_a), 64'd2);
    check("b2b_rise_after_done", 64'(r_b), (done_q.size() > d0) ? 64'(done_q[d0] + 1) : 64'hFFFF);
    check("b2b_rd_count", 64'(rds.size() - r0), 64'd2);
    check("b2b_rd0", (rds.size() > r0) ? 64'(rds[r0]) : 64'hFFFF_FFFF_F, 64'(rd_tab[0]));
    check("b2b_rd1", (rds.size() > r0 + 1) ? 64'(rds[r0 + 1]) : 64'hFFFF_FFFF_F, 64'(rd_tab[1]));
    check("b2b_addr0", (beats.size() > b0) ? 64'(beats[b0][61:36]) : 64'hFFFF_FFFF, 64'h0000A00);
    check("b2b_addr1", (beats.size() > b0 + 1) ? 64'(beats[b0 + 1][61:36]) : 64'hFFFF_FFFF, 64'h0000B00);

    for (int t = 0; t < 12; t++) begin
      len = ($urandom_range(3) == 0) ? int'($urandom_range(40)) : int'($urandom_range(5));
      w = 1'($urandom_range(1));
      a = ($urandom_range(1) == 1) ? AW'($urandom) : 26'h3FFFFFF - AW'($urandom_range(3));
      fill(len, 0);
      for (int i = 0; i <= len; i++) wait_tab[i] = $urandom_range(3);
      if ($urandom_range(3) == 0) wait_tab[$urandom_range(len)] = TO - 1 + $urandom_range(2);
      run_cmd($sformatf("rand%0d", t), w, a, 4'($urandom_range(1, 15)), len);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end
endmodule
